// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the MTM ALU scheduler: FSM states, the idle
// control code, the three error codes and the ALU op encodings.
package mtm_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] IDLE_CTL = 8'hFF;

    localparam logic [7:0] ERR_CRC  = 8'hA5;
    localparam logic [7:0] ERR_DATA = 8'hC9;
    localparam logic [7:0] ERR_OP   = 8'h93;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    function automatic logic is_err_code(input logic [7:0] c);
        return (c == ERR_CRC) || (c == ERR_DATA) || (c == ERR_OP);
    endfunction

endpackage

// File: rtl/mtm_rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, preferring the requester
// not granted last when both request. No grant unless enabled.
module mtm_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_gnt ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/mtm_alu_sched.sv
// Shares one registered ALU core between two requesters, one operation in
// flight at a time, with error-code bypass and handshake statistics.
module mtm_alu_sched
    import mtm_alu_pkg::*;
#(
    parameter int CORE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    input  logic [31:0] req_A_0,
    input  logic [31:0] req_B_0,
    input  logic [31:0] req_A_1,
    input  logic [31:0] req_B_1,
    input  logic [7:0]  req_ctl_0,
    input  logic [7:0]  req_ctl_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_0,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_C_0,
    output logic [31:0] rsp_C_1,
    output logic [7:0]  rsp_ctl_0,
    output logic [7:0]  rsp_ctl_1,
    output logic [31:0] core_A,
    output logic [31:0] core_B,
    output logic [7:0]  core_ctl,
    input  logic [31:0] core_C,
    input  logic [7:0]  core_ctl_out,
    input  logic        cnt_clr,
    output logic [15:0] op_cnt,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] LAT_LD = 4'(CORE_LAT);

    state_t      state, state_nxt;
    logic        last_gnt;
    logic        gnt_idx;
    logic [7:0]  ctl_lat;
    logic [3:0]  wait_cnt;
    logic [31:0] res_c;
    logic [7:0]  res_ctl;

    logic [1:0]  gnt;
    logic        xfer;
    logic        sel_idx;
    logic [31:0] sel_a, sel_b;
    logic [7:0]  sel_ctl;
    logic        rdy_sel;
    logic        hs;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    mtm_rr_arb2 u_arb (
        .req      ({req_valid_1, req_valid_0}),
        .last_gnt (last_gnt),
        .en       ((state == ST_IDLE) && !rst),
        .gnt      (gnt)
    );

    assign req_ready_0 = gnt[0];
    assign req_ready_1 = gnt[1];
    assign xfer        = |gnt;
    assign sel_idx     = gnt[1];
    assign sel_a       = sel_idx ? req_A_1   : req_A_0;
    assign sel_b       = sel_idx ? req_B_1   : req_B_0;
    assign sel_ctl     = sel_idx ? req_ctl_1 : req_ctl_0;
    assign rdy_sel     = gnt_idx ? rsp_ready_1 : rsp_ready_0;
    assign hs          = (state == ST_RESP) && rdy_sel;

    always_comb begin
        state_nxt   = state;
        core_ctl    = IDLE_CTL;
        rsp_valid_0 = 1'b0;
        rsp_valid_1 = 1'b0;
        rsp_C_0     = '0;
        rsp_C_1     = '0;
        rsp_ctl_0   = '0;
        rsp_ctl_1   = '0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_nxt = is_err_code(sel_ctl) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_ctl  = ctl_lat;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (gnt_idx) begin
                    rsp_valid_1 = 1'b1;
                    rsp_C_1     = res_c;
                    rsp_ctl_1   = res_ctl;
                end else begin
                    rsp_valid_0 = 1'b1;
                    rsp_C_0     = res_c;
                    rsp_ctl_0   = res_ctl;
                end
                if (rdy_sel) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Transfer, issue and capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last_gnt <= 1'b1;
            gnt_idx  <= 1'b0;
            ctl_lat  <= IDLE_CTL;
            wait_cnt <= '0;
            core_A   <= '0;
            core_B   <= '0;
            res_c    <= '0;
            res_ctl  <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                gnt_idx <= sel_idx;
                ctl_lat <= sel_ctl;
                // Bypassed errors never reach the core, so its operands stay put.
                if (is_err_code(sel_ctl)) begin
                    res_c   <= '0;
                    res_ctl <= sel_ctl;
                end else begin
                    core_A <= sel_a;
                    core_B <= sel_b;
                end
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= LAT_LD;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if ((state == ST_WAIT) && (wait_cnt == 4'd1)) begin
                res_c   <= core_C;
                res_ctl <= core_ctl_out;
            end
            if (hs) begin
                last_gnt <= gnt_idx;
            end
        end
    end

    // Statistics: clear has priority over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            op_cnt  <= '0;
            err_cnt <= '0;
        end else if (hs) begin
            op_cnt <= op_cnt + 16'd1;
            if (is_err_code(res_ctl)) begin
                err_cnt <= sat_inc8(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_sched.sv
// Randomized bench for mtm_alu_sched: a registered ALU core model plus a
// transaction-level reference that predicts grants, timing and counters.
module tb_mtm_alu_sched;
    import mtm_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_A_0, req_B_0, req_A_1, req_B_1;
    logic [7:0]  req_ctl_0, req_ctl_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_C_0, rsp_C_1;
    logic [7:0]  rsp_ctl_0, rsp_ctl_1;
    logic [31:0] core_A, core_B, core_C;
    logic [7:0]  core_ctl, core_ctl_out;
    logic        cnt_clr;
    logic [15:0] op_cnt;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    mtm_alu_sched #(.CORE_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_0  (req_valid_0),
        .req_valid_1  (req_valid_1),
        .req_ready_0  (req_ready_0),
        .req_ready_1  (req_ready_1),
        .req_A_0      (req_A_0),
        .req_B_0      (req_B_0),
        .req_A_1      (req_A_1),
        .req_B_1      (req_B_1),
        .req_ctl_0    (req_ctl_0),
        .req_ctl_1    (req_ctl_1),
        .rsp_valid_0  (rsp_valid_0),
        .rsp_valid_1  (rsp_valid_1),
        .rsp_ready_0  (rsp_ready_0),
        .rsp_ready_1  (rsp_ready_1),
        .rsp_C_0      (rsp_C_0),
        .rsp_C_1      (rsp_C_1),
        .rsp_ctl_0    (rsp_ctl_0),
        .rsp_ctl_1    (rsp_ctl_1),
        .core_A       (core_A),
        .core_B       (core_B),
        .core_ctl     (core_ctl),
        .core_C       (core_C),
        .core_ctl_out (core_ctl_out),
        .cnt_clr      (cnt_clr),
        .op_cnt       (op_cnt),
        .err_cnt      (err_cnt)
    );

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [7:0] c);
        case (c[6:4])
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return 32'd0;
        endcase
    endfunction

    // ALU core with one cycle of latency; status byte is a fixed scramble of the control byte
    always_ff @(posedge clk) begin
        core_C       <= alu(core_A, core_B, core_ctl);
        core_ctl_out <= core_ctl ^ 8'h3C;
    end

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    bit          busy = 1'b0;
    bit          m_last = 1'b1;
    bit          g;
    bit          m_err;
    int          t0, due;
    logic [7:0]  m_ctl, e_ctl;
    logic [31:0] e_c;
    logic [31:0] m_ca = '0, m_cb = '0;
    logic [15:0] m_op = '0;
    logic [7:0]  m_errc = '0;

    int p_valid, p_rdy, p_err, p_clr, p_rst;

    function automatic logic [7:0] gen_ctl();
        logic [2:0] op;
        if ($urandom_range(0, 99) < p_err) begin
            case ($urandom_range(0, 2))
                0:       return 8'hA5;
                1:       return 8'hC9;
                default: return 8'h93;
            endcase
        end
        case ($urandom_range(0, 4))
            0:       op = OP_AND;
            1:       op = OP_OR;
            2:       op = OP_ADD;
            3:       op = OP_SUB;
            default: op = 3'($urandom_range(0, 7));
        endcase
        return {1'b0, op, 4'($urandom_range(0, 15))};
    endfunction

    task automatic drive();
        req_valid_0 = ($urandom_range(0, 99) < p_valid);
        req_valid_1 = ($urandom_range(0, 99) < p_valid);
        req_A_0     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_B_0     = $urandom;
        req_A_1     = $urandom;
        req_B_1     = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
        req_ctl_0   = gen_ctl();
        req_ctl_1   = gen_ctl();
        rsp_ready_0 = ($urandom_range(0, 99) < p_rdy);
        rsp_ready_1 = ($urandom_range(0, 99) < p_rdy);
        cnt_clr     = ($urandom_range(0, 99) < p_clr);
        rst         = ($urandom_range(0, 999) < p_rst);
    endtask

    task automatic step_model();
        logic [1:0]  v;
        logic [1:0]  exp_v;
        logic [31:0] a, b;
        logic [7:0]  c;
        int          d;
        bit          hs;
        v  = {req_valid_1, req_valid_0};
        hs = 1'b0;
        if (rst) begin
            chk("ready_in_rst", 64'({req_ready_1, req_ready_0}), 64'd0);
            busy   = 1'b0;
            m_last = 1'b1;
            m_op   = '0;
            m_errc = '0;
            m_ca   = '0;
            m_cb   = '0;
            return;
        end
        chk("op_cnt", 64'(op_cnt), 64'(m_op));
        chk("err_cnt", 64'(err_cnt), 64'(m_errc));
        chk("core_A", 64'(core_A), 64'(m_ca));
        chk("core_B", 64'(core_B), 64'(m_cb));
        if (!busy) begin
            g = (v == 2'b11) ? ~m_last : v[1];
            chk("req_ready", 64'({req_ready_1, req_ready_0}),
                64'((v == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01)));
            chk("rsp_valid_idle", 64'({rsp_valid_1, rsp_valid_0}), 64'd0);
            chk("rsp_data_idle", {rsp_C_1, rsp_C_0}, 64'd0);
            chk("core_ctl_idle", 64'(core_ctl), 64'(IDLE_CTL));
            if (v != 2'b00) begin
                a     = g ? req_A_1 : req_A_0;
                b     = g ? req_B_1 : req_B_0;
                c     = g ? req_ctl_1 : req_ctl_0;
                busy  = 1'b1;
                t0    = cyc;
                m_ctl = c;
                m_err = (c == 8'hA5) || (c == 8'hC9) || (c == 8'h93);
                if (m_err) begin
                    e_c   = '0;
                    e_ctl = c;
                    due   = 1;
                end else begin
                    e_c   = alu(a, b, c);
                    e_ctl = c ^ 8'h3C;
                    due   = 3;
                    m_ca  = a;
                    m_cb  = b;
                end
            end
        end else begin
            d = cyc - t0;
            chk("ready_busy", 64'({req_ready_1, req_ready_0}), 64'd0);
            chk("core_ctl", 64'(core_ctl), 64'((!m_err && d == 1) ? m_ctl : IDLE_CTL));
            exp_v = (d >= due) ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("rsp_valid", 64'({rsp_valid_1, rsp_valid_0}), 64'(exp_v));
            if (d >= due) begin
                chk("rsp_C", 64'(g ? rsp_C_1 : rsp_C_0), 64'(e_c));
                chk("rsp_ctl", 64'(g ? rsp_ctl_1 : rsp_ctl_0), 64'(e_ctl));
                chk("rsp_other_zero",
                    g ? {24'd0, rsp_ctl_0, rsp_C_0} : {24'd0, rsp_ctl_1, rsp_C_1}, 64'd0);
                hs = g ? rsp_ready_1 : rsp_ready_0;
                if (hs) begin
                    busy   = 1'b0;
                    m_last = g;
                end
            end else begin
                chk("rsp_data_wait", {rsp_C_1, rsp_C_0}, 64'd0);
            end
        end
        if (cnt_clr) begin
            m_op   = '0;
            m_errc = '0;
        end else if (hs) begin
            m_op = m_op + 16'd1;
            if (m_err && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
        end
    endtask

    task automatic run_phase(input int n, input int pv, input int pr, input int pe,
                             input int pc, input int prst);
        p_valid = pv;
        p_rdy   = pr;
        p_err   = pe;
        p_clr   = pc;
        p_rst   = prst;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            drive();
            @(negedge clk);
            cyc++;
            step_model();
        end
    endtask

    initial begin
        rst = 1'b1;
        {req_valid_0, req_valid_1, rsp_ready_0, rsp_ready_1, cnt_clr} = '0;
        {req_A_0, req_B_0, req_A_1, req_B_1} = '0;
        req_ctl_0 = '0;
        req_ctl_1 = '0;
        run_phase(3, 0, 0, 0, 0, 1000);
        run_phase(2500, 60, 60, 20, 2, 2);
        // Contention with heavy backpressure
        run_phase(800, 100, 20, 10, 0, 0);
        // Back-to-back error ops drive err_cnt into saturation
        run_phase(1200, 100, 100, 100, 0, 0);
        chk("err_cnt_sat", 64'(err_cnt), 64'h00FF);
        run_phase(600, 70, 50, 40, 10, 5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
